// File: rtl/sccpu_dbg_pkg.sv
// Shared definitions for the sccomp run-control / state-dump engine:
// FSM state encoding and halt-cause codes.
package sccpu_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_HDR_PC,
        ST_HDR_IN,
        ST_DUMP,
        ST_DONE
    } state_t;

    localparam logic [1:0] HALT_NONE  = 2'd0;
    localparam logic [1:0] HALT_BP    = 2'd1;
    localparam logic [1:0] HALT_LIMIT = 2'd2;
    localparam logic [1:0] HALT_BADPC = 2'd3;

    // Only called on a hit, so "neither bad nor bp" means the cycle limit fired.
    function automatic logic [1:0] halt_code(input logic bad_pc, input logic bp);
        if (bad_pc)
            return HALT_BADPC;
        else if (bp)
            return HALT_BP;
        else
            return HALT_LIMIT;
    endfunction

endpackage

// File: rtl/sccpu_bp_match.sv
// Breakpoint comparator bank: NBP address compares, OR-reduced into one match flag.
module sccpu_bp_match #(
    parameter int AW  = 32,
    parameter int NBP = 4
) (
    input  logic [AW-1:0]     pc,
    input  logic              pc_valid,
    input  logic [NBP*AW-1:0] bp_addr,
    input  logic [NBP-1:0]    bp_en,
    output logic              match
);

    logic [NBP-1:0] slot_hit;

    for (genvar i = 0; i < NBP; i++) begin : g_slot
        assign slot_hit[i] = bp_en[i] & pc_valid & (pc == bp_addr[i*AW +: AW]);
    end

    assign match = |slot_hit;

endmodule

// File: rtl/sccpu_trace_dump.sv
// Run-control and state-dump engine for sccomp: runs the CPU until a breakpoint,
// cycle limit or invalid PC, then streams PC, instr and rf[0..NREG-1] to a sink.
module sccpu_trace_dump
    import sccpu_dbg_pkg::*;
#(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int NBP  = 4,
    parameter int CW   = 16,
    localparam int RSW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic [AW-1:0]     pc,
    input  logic              pc_valid,
    input  logic [DW-1:0]     instr,
    input  logic [NBP*AW-1:0] bp_addr,
    input  logic [NBP-1:0]    bp_en,
    input  logic [CW-1:0]     cycle_limit,
    output logic              cpu_stall,
    output logic [RSW-1:0]    reg_sel,
    input  logic [DW-1:0]     reg_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DW-1:0]     dump_data,
    output logic              done,
    output logic [1:0]        halt_cause,
    output logic [CW-1:0]     cycle_count
);

    state_t          state, state_nxt;
    logic            bp_hit, limit_hit, hit, load, last_word;
    logic [RSW-1:0]  idx;
    logic [DW-1:0]   instr_lat;

    sccpu_bp_match #(.AW(AW), .NBP(NBP)) u_bp_match (
        .pc       (pc),
        .pc_valid (pc_valid),
        .bp_addr  (bp_addr),
        .bp_en    (bp_en),
        .match    (bp_hit)
    );

    assign limit_hit = (cycle_limit != '0) && (cycle_count == cycle_limit);
    assign hit       = ~pc_valid | bp_hit | limit_hit;
    assign load      = ~dump_valid | dump_ready;
    assign reg_sel   = idx;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (run_en)           state_nxt = ST_RUN;
            ST_RUN:           if (hit)              state_nxt = ST_HDR_PC;
            ST_HDR_PC:        if (load)             state_nxt = ST_HDR_IN;
            ST_HDR_IN:        if (load)             state_nxt = ST_DUMP;
            ST_DUMP:          if (load && last_word) state_nxt = ST_DONE;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    // The CPU only advances in RUN, and is held off in the hit cycle so the
    // halting instruction never retires.
    always_comb begin
        cpu_stall = 1'b1;
        if (state == ST_RUN)
            cpu_stall = hit;
    end

    // State named after the word currently held in the output register;
    // the PC word is loaded directly on the hit so no bubble precedes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            done        <= 1'b0;
            halt_cause  <= HALT_NONE;
            cycle_count <= '0;
            idx         <= '0;
            last_word   <= 1'b0;
            instr_lat   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (run_en) begin
                        cycle_count <= '0;
                        halt_cause  <= HALT_NONE;
                        done        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (hit) begin
                        instr_lat  <= instr;
                        halt_cause <= halt_code(~pc_valid, bp_hit);
                        dump_data  <= DW'(pc);
                        dump_valid <= 1'b1;
                        idx        <= '0;
                        last_word  <= 1'b0;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CW'(1);
                    end
                end
                ST_HDR_PC: begin
                    if (load)
                        dump_data <= instr_lat;
                end
                ST_HDR_IN: begin
                    if (load) begin
                        dump_data <= '0;
                        idx       <= RSW'(1);
                        last_word <= (NREG == 1);
                    end
                end
                ST_DUMP: begin
                    if (load) begin
                        if (last_word) begin
                            dump_valid <= 1'b0;
                            done       <= 1'b1;
                            idx        <= '0;
                            last_word  <= 1'b0;
                        end else begin
                            dump_data <= reg_data;
                            last_word <= (idx == RSW'(NREG - 1));
                            idx       <= idx + RSW'(1);
                        end
                    end
                end
                default: begin
                    dump_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccpu_trace_dump.sv
// Directed bench for sccpu_trace_dump: a toy CPU advances PC by 4 and writes
// pc|1 into rf[pc/4] per retired instruction; dumps are checked word by word.
module tb_sccpu_trace_dump;

    localparam int AW = 32, DW = 32, NREG = 32, NBP = 4, CW = 16;

    logic              clk = 1'b0;
    logic              rst, run_en, pc_valid, dump_ready;
    logic              cpu_stall, dump_valid, done;
    logic [AW-1:0]     pc;
    logic [DW-1:0]     instr, reg_data, dump_data;
    logic [NBP*AW-1:0] bp_addr;
    logic [NBP-1:0]    bp_en;
    logic [CW-1:0]     cycle_limit, cycle_count;
    logic [4:0]        reg_sel;
    logic [1:0]        halt_cause;

    logic              cpu_rst, bad_en;
    logic [31:0]       cpu_pc, bad_pc;
    logic [31:0]       rf [NREG];
    logic [31:0]       sink [$];
    int                vectors = 0, miscompares = 0;
    int                vc;

    always #5 clk = ~clk;

    sccpu_trace_dump #(.AW(AW), .DW(DW), .NREG(NREG), .NBP(NBP), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .instr       (instr),
        .bp_addr     (bp_addr),
        .bp_en       (bp_en),
        .cycle_limit (cycle_limit),
        .cpu_stall   (cpu_stall),
        .reg_sel     (reg_sel),
        .reg_data    (reg_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .done        (done),
        .halt_cause  (halt_cause),
        .cycle_count (cycle_count)
    );

    // Toy single-cycle CPU
    assign pc       = cpu_pc;
    assign instr    = 32'hA000_0000 | cpu_pc;
    assign pc_valid = !(bad_en && cpu_pc == bad_pc);
    assign reg_data = rf[reg_sel];

    always @(posedge clk) begin
        if (cpu_rst) begin
            cpu_pc <= '0;
            for (int r = 0; r < NREG; r++) rf[r] <= 32'hC0DE_0000 + r;
        end else if (!cpu_stall) begin
            rf[cpu_pc[6:2]] <= cpu_pc | 32'd1;
            cpu_pc          <= cpu_pc + 32'd4;
        end
    end

    always @(posedge clk)
        if (!rst && dump_valid && dump_ready) sink.push_back(dump_data);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_reset();
        @(negedge clk) cpu_rst = 1'b1;
        @(negedge clk) cpu_rst = 1'b0;
    endtask

    task automatic start_run();
        sink.delete();
        @(negedge clk) run_en = 1'b1;
        @(negedge clk) run_en = 1'b0;
        chk("run_cc0", 32'(cycle_count), 32'd0);
        chk("run_stall0", 32'(cpu_stall), 32'd0);
    endtask

    // Walk until done, driving ready from a 4-cycle pattern and checking the
    // output word is held across every cycle the sink refused it.
    task automatic wait_done(input logic [3:0] pat, output int vcyc);
        logic        ok = 1'b0, stalled = 1'b0;
        logic [31:0] prev = '0;
        vcyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (stalled && dump_valid) chk("hold", dump_data, prev);
            if (done) begin ok = 1'b1; break; end
            if (dump_valid) vcyc++;
            dump_ready = pat[i % 4];
            stalled    = dump_valid && !dump_ready;
            prev       = dump_data;
        end
        dump_ready = 1'b1;
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    task automatic check_dump(input logic [31:0] hpc);
        logic [31:0] exp;
        int          r;
        chk("nwords", 32'(sink.size()), 32'd34);
        for (int w = 0; w < 34 && w < sink.size(); w++) begin
            r = w - 2;
            if (w == 0)      exp = hpc;
            else if (w == 1) exp = 32'hA000_0000 | hpc;
            else if (w == 2) exp = 32'd0;
            else if (r < int'(hpc >> 2)) exp = 32'(4 * r + 1);
            else             exp = 32'hC0DE_0000 + 32'(r);
            chk($sformatf("word%0d", w), sink[w], exp);
        end
    endtask

    initial begin
        rst = 1'b1; cpu_rst = 1'b1; run_en = 1'b0; dump_ready = 1'b1;
        bp_addr = '0; bp_en = '0; cycle_limit = '0; bad_en = 1'b0; bad_pc = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; cpu_rst = 1'b0;
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_data", dump_data, 32'd0);
        chk("rst_sel", 32'(reg_sel), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cause", 32'(halt_cause), 32'd0);
        chk("rst_cc", 32'(cycle_count), 32'd0);

        // 1: breakpoint at 0x48, ready held high
        bp_addr[0 +: 32] = 32'h48; bp_en = 4'b0001;
        start_run();
        wait_done(4'b1111, vc);
        check_dump(32'h48);
        chk("t1_cause", 32'(halt_cause), 32'd1);
        chk("t1_cc", 32'(cycle_count), 32'd18);
        chk("t1_vcyc", 32'(vc), 32'd34);
        chk("t1_pc_frozen", cpu_pc, 32'h48);
        chk("t1_stall", 32'(cpu_stall), 32'd1);
        chk("t1_valid", 32'(dump_valid), 32'd0);

        // 2: cycle limit 10, restarted from DONE
        cpu_reset();
        bp_en = 4'b0000; cycle_limit = 16'd10;
        start_run();
        wait_done(4'b1111, vc);
        check_dump(32'h28);
        chk("t2_cause", 32'(halt_cause), 32'd2);
        chk("t2_cc", 32'(cycle_count), 32'd10);

        // 3: invalid PC coinciding with a breakpoint
        cpu_reset();
        cycle_limit = '0; bp_addr[32 +: 32] = 32'h14; bp_en = 4'b0010;
        bad_pc = 32'h14; bad_en = 1'b1;
        start_run();
        wait_done(4'b1111, vc);
        bad_en = 1'b0;
        check_dump(32'h14);
        chk("t3_cause", 32'(halt_cause), 32'd3);
        chk("t3_cc", 32'(cycle_count), 32'd5);

        // 4: ready pattern 1,0,0,1; disabled slot0 matches earlier pc 0x10
        cpu_reset();
        bp_addr[0 +: 32] = 32'h10; bp_addr[64 +: 32] = 32'h20; bp_en = 4'b0100;
        start_run();
        wait_done(4'b1001, vc);
        check_dump(32'h20);
        chk("t4_cause", 32'(halt_cause), 32'd1);
        chk("t4_cc", 32'(cycle_count), 32'd8);

        // 5: reset in the middle of the register dump
        cpu_reset();
        bp_addr[0 +: 32] = 32'h8; bp_en = 4'b0001;
        start_run();
        begin
            logic reached = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (sink.size() >= 7) begin reached = 1'b1; break; end
            end
            chk("t5_reached", 32'(reached), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_valid", 32'(dump_valid), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_stall", 32'(cpu_stall), 32'd1);
        chk("t5_cause", 32'(halt_cause), 32'd0);
        chk("t5_cc", 32'(cycle_count), 32'd0);

        // 6: unlimited run with no breakpoints never halts
        cpu_reset();
        bp_en = 4'b0000; cycle_limit = '0;
        start_run();
        repeat (40) @(negedge clk);
        chk("t6_cc", 32'(cycle_count), 32'd40);
        chk("t6_stall", 32'(cpu_stall), 32'd0);
        chk("t6_valid", 32'(dump_valid), 32'd0);
        chk("t6_cause", 32'(halt_cause), 32'd0);
        chk("t6_pc", cpu_pc, 32'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
